icmp_parser: RTL
================

# icmp_parser

Receive-side ICMP echo-request parser. Consumes the raw byte stream from the Ethernet MAC RX path, filters and validates Ethernet/IPv4/ICMP echo requests addressed to this node, and presents each accepted request as an `ether_icmp_frame_t` (from `icmp_pkg`) to `icmp_sender` through a single-entry valid/ack output register. It sits directly upstream of `icmp_sender`.

## Interface
- No parameters. Sizes come from `icmp_pkg`: `lp_IP_HDR_SZ`, `lp_ICMP_HDR_SZ`, `lp_ICMP_DATA_SZ`, `lp_ICMP_FRM_SZ` (14 + 20 + 8 + data bytes).
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `hw_addr_i`  in  48  own MAC address.
- `ip_addr_i`  in  32  own IPv4 address.
- `mac_data_i`  in  8  RX byte, MSB-first frame order, FCS already stripped.
- `mac_valid_i`  in  1  `mac_data_i` valid this cycle.
- `mac_last_i`  in  1  last byte of frame; qualified by `mac_valid_i`.
- `icmp_req_pkt_o`  out  `$bits(ether_icmp_frame_t)`  accepted request.
- `icmp_req_pkt_valid_o`  out  1  `icmp_req_pkt_o` holds an unconsumed request.
- `icmp_req_pkt_ack_i`  in  1  1-cycle consume strobe from `icmp_sender`.
- `rx_ok_cnt_o`  out  16  accepted request count, wraps.
- `rx_drop_cnt_o`  out  16  rejected/dropped frame count, wraps.

## Operation
- Byte index 0 maps to `dst_mac[47:40]`. Bytes `0..lp_ICMP_FRM_SZ-1` shift into a capture register in struct bit order. Bytes beyond that (Ethernet padding) are ignored.
- Byte counter is 11 bits and saturates at 2047.
- State machine:
  - ST_IDLE → ST_RECV on `mac_valid_i` (byte 0 is captured on that cycle). If `mac_last_i` is also set, go to ST_CHECK.
  - ST_RECV → ST_CHECK on the byte with `mac_last_i`.
  - ST_RECV → ST_DISCARD on early reject, which is a mismatch detectable on the fly:
    - dst_mac not equal to `hw_addr_i` and not all-ones, or
    - ethertype ≠ 0x0800, or
    - version/IHL byte ≠ 0x45, or
    - protocol ≠ 0x01.
  - ST_DISCARD → ST_IDLE on the `mac_last_i` byte. The frame is counted as a drop.
  - ST_CHECK always lasts one cycle, then → ST_IDLE.
- Checksums are one's-complement sums of 16-bit big-endian words, accumulated on the fly with end-around carry. The IP sum covers bytes 14..33; the ICMP sum covers bytes 34..`lp_ICMP_FRM_SZ-1`. Each sum is valid when it equals 0xFFFF.
- Acceptance in ST_CHECK requires all of:
  - byte count ≥ `lp_ICMP_FRM_SZ`
  - `ip_dst == ip_addr_i`
  - `ip_length == lp_IP_HDR_SZ + lp_ICMP_HDR_SZ + lp_ICMP_DATA_SZ`
  - MF flag = 0 and `ip_frag_off` = 0
  - `icmp_type` = 8 and `icmp_code` = 0
  - both checksums valid
- Accepted and output register empty, or emptied by an ack in the same cycle: load `icmp_req_pkt_o`, set valid, increment `rx_ok_cnt_o`.
- Accepted but output register full: drop, increment `rx_drop_cnt_o`. Output is not overwritten.
- Rejected: increment `rx_drop_cnt_o`.
- Exactly one counter increments per frame.
- Output register: valid clears on `icmp_req_pkt_ack_i`. `icmp_req_pkt_o` stays stable while valid is high.

## Timing
- Reset values: `icmp_req_pkt_valid_o` = 0, `icmp_req_pkt_o` = 0, both counters = 0, state ST_IDLE, capture register and sums cleared.
- Latency: last byte sampled at edge E; verdict computed in ST_CHECK; `icmp_req_pkt_valid_o` is high after edge E+2.
- Ack and load in the same cycle: the load wins, and valid stays high with the new frame.
- Ack while valid is low is ignored.
- `mac_valid_i` during ST_CHECK: that frame is treated as bad and followed through ST_DISCARD until `mac_last_i`. The MAC guarantees an inter-frame gap ≥ 1 cycle.
- `mac_valid_i` low mid-frame: stall. No state change, nothing captured.
- Reset mid-frame: the partial frame is discarded with no counter increment. The next `mac_valid_i` after reset release is byte 0.
- A single-byte frame (valid and last together) is a short frame and is dropped.

## Test plan
- Well-formed echo request addressed to us, with correct checksums, plus 4 pad bytes → valid high 2 cycles after last byte. Fields equal the input (e.g. `icmp_id` 0x1234, `icmp_seq` 0x0001). `rx_ok_cnt_o` = 1.
- Same frame with dst_mac = FF:FF:FF:FF:FF:FF → accepted. With dst_mac = another MAC → ST_DISCARD, `rx_drop_cnt_o` +1, valid stays 0.
- IP checksum off by 1, then ICMP checksum off by 1, then `ip_dst` ≠ `ip_addr_i`, then `icmp_type` = 0 → each dropped. `rx_drop_cnt_o` = 4, `rx_ok_cnt_o` unchanged.
- Two valid requests back-to-back, no ack → first held stable and second dropped (drop +1). Then ack the first; a third request is accepted.
- Ack asserted in the same cycle the next request is loaded → valid stays high and the output shows the new frame's `icmp_seq`.
- Frame truncated at byte 30 with `mac_last_i` → dropped. Reset asserted mid-frame → no counter change, and the next full frame is accepted.

Source files
------------

// File: rtl/icmp_parser.sv
// ICMP echo-request receive parser. Captures Ethernet/IPv4/ICMP frames from
// the MAC RX byte stream, validates them, and hands accepted echo requests to
// the sender through a single-entry valid/ack output register.
//
// Output handshake: icmp_req_pkt_valid_o rises when a request is loaded and
// stays high, with icmp_req_pkt_o frozen, until a one-cycle
// icmp_req_pkt_ack_i consumes it; a load in the same cycle as an ack wins.

package icmp_pkg;
    localparam int lp_ETH_HDR_SZ   = 14;
    localparam int lp_IP_HDR_SZ    = 20;
    localparam int lp_ICMP_HDR_SZ  = 8;
    localparam int lp_ICMP_DATA_SZ = 8;
    localparam int lp_ICMP_FRM_SZ  = lp_ETH_HDR_SZ + lp_IP_HDR_SZ + lp_ICMP_HDR_SZ + lp_ICMP_DATA_SZ;

    // Fields in wire order: byte 0 of the frame lands in the MSBs.
    typedef struct packed {
        logic [47:0]                  dst_mac;
        logic [47:0]                  src_mac;
        logic [15:0]                  ethertype;
        logic [7:0]                   ip_ver_ihl;
        logic [7:0]                   ip_tos;
        logic [15:0]                  ip_length;
        logic [15:0]                  ip_id;
        logic [2:0]                   ip_flags;     // [0] is MF
        logic [12:0]                  ip_frag_off;
        logic [7:0]                   ip_ttl;
        logic [7:0]                   ip_proto;
        logic [15:0]                  ip_checksum;
        logic [31:0]                  ip_src;
        logic [31:0]                  ip_dst;
        logic [7:0]                   icmp_type;
        logic [7:0]                   icmp_code;
        logic [15:0]                  icmp_checksum;
        logic [15:0]                  icmp_id;
        logic [15:0]                  icmp_seq;
        logic [lp_ICMP_DATA_SZ*8-1:0] icmp_data;
    } ether_icmp_frame_t;
endpackage

module icmp_parser
    import icmp_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [47:0]                          hw_addr_i,
    input  logic [31:0]                          ip_addr_i,
    input  logic [7:0]                           mac_data_i,
    input  logic                                 mac_valid_i,
    input  logic                                 mac_last_i,
    output logic [$bits(ether_icmp_frame_t)-1:0] icmp_req_pkt_o,
    output logic                                 icmp_req_pkt_valid_o,
    input  logic                                 icmp_req_pkt_ack_i,
    output logic [15:0]                          rx_ok_cnt_o,
    output logic [15:0]                          rx_drop_cnt_o
);
    localparam int          FRM_BITS   = $bits(ether_icmp_frame_t);
    localparam logic [10:0] FRM_LEN    = 11'(lp_ICMP_FRM_SZ);
    localparam logic [10:0] IP_FIRST   = 11'(lp_ETH_HDR_SZ);
    localparam logic [10:0] ICMP_FIRST = 11'(lp_ETH_HDR_SZ + lp_IP_HDR_SZ);
    localparam logic [10:0] CNT_MAX    = 11'h7FF;
    localparam logic [15:0] IP_LEN     = 16'(lp_IP_HDR_SZ + lp_ICMP_HDR_SZ + lp_ICMP_DATA_SZ);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DISCARD, ST_CHECK} state_t;

    state_t            state_q, state_nxt;
    logic [10:0]       byte_cnt_q;
    ether_icmp_frame_t cap_q, out_q;
    logic [15:0]       ip_sum_q, icmp_sum_q;
    logic              hdr_bad_q;
    logic              verdict_vld_q, verdict_ok_q;
    logic              out_valid_q;
    logic [15:0]       ok_cnt_q, drop_cnt_q;

    logic [15:0]       word_in;
    logic [47:0]       dst_in;
    logic              early_rej, check_ok, discard_done, load;

    // One's-complement add with end-around carry.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Current byte joined with already-captured bytes for multi-byte fields.
    assign word_in = {cap_q[7:0], mac_data_i};
    assign dst_in  = {cap_q[39:0], mac_data_i};

    // Header mismatches that can be spotted as the relevant byte arrives.
    always_comb begin
        early_rej = 1'b0;
        if (state_q == ST_RECV && mac_valid_i) begin
            if (byte_cnt_q == 11'd5 && dst_in != hw_addr_i && dst_in != '1) early_rej = 1'b1;
            if (byte_cnt_q == 11'd13 && word_in != 16'h0800)                 early_rej = 1'b1;
            if (byte_cnt_q == IP_FIRST && mac_data_i != 8'h45)               early_rej = 1'b1;
            if (byte_cnt_q == IP_FIRST + 11'd9 && mac_data_i != 8'h01)       early_rej = 1'b1;
        end
    end

    // Full verdict on the captured frame, evaluated while in ST_CHECK.
    always_comb begin
        check_ok = !hdr_bad_q
                && (byte_cnt_q >= FRM_LEN)
                && (cap_q.ip_dst == ip_addr_i)
                && (cap_q.ip_length == IP_LEN)
                && !cap_q.ip_flags[0]
                && (cap_q.ip_frag_off == 13'd0)
                && (cap_q.icmp_type == 8'd8)
                && (cap_q.icmp_code == 8'd0)
                && (ip_sum_q == 16'hFFFF)
                && (icmp_sum_q == 16'hFFFF);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state logic; a frame starting during ST_CHECK is discarded.
    always_comb begin
        state_nxt    = state_q;
        discard_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mac_valid_i) state_nxt = mac_last_i ? ST_CHECK : ST_RECV;
            end
            ST_RECV: begin
                if (mac_valid_i) begin
                    if (mac_last_i)     state_nxt = ST_CHECK;
                    else if (early_rej) state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mac_valid_i && mac_last_i) begin
                    state_nxt    = ST_IDLE;
                    discard_done = 1'b1;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                if (mac_valid_i) begin
                    if (mac_last_i) discard_done = 1'b1;
                    else            state_nxt    = ST_DISCARD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Byte capture, byte counting and on-the-fly checksum accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            cap_q      <= '0;
            ip_sum_q   <= '0;
            icmp_sum_q <= '0;
            hdr_bad_q  <= 1'b0;
        end else if (mac_valid_i && state_q == ST_IDLE) begin
            byte_cnt_q <= 11'd1;
            cap_q      <= ether_icmp_frame_t'(FRM_BITS'(mac_data_i));
            ip_sum_q   <= '0;
            icmp_sum_q <= '0;
            hdr_bad_q  <= 1'b0;
        end else if (mac_valid_i && state_q == ST_RECV) begin
            if (byte_cnt_q != CNT_MAX) byte_cnt_q <= byte_cnt_q + 11'd1;
            if (byte_cnt_q < FRM_LEN)  cap_q <= {cap_q[FRM_BITS-9:0], mac_data_i};
            if (byte_cnt_q[0] && byte_cnt_q > IP_FIRST && byte_cnt_q < ICMP_FIRST)
                ip_sum_q <= ones_add(ip_sum_q, word_in);
            if (byte_cnt_q[0] && byte_cnt_q > ICMP_FIRST && byte_cnt_q < FRM_LEN)
                icmp_sum_q <= ones_add(icmp_sum_q, word_in);
            if (early_rej) hdr_bad_q <= 1'b1;
        end
    end

    // Register the verdict, then commit it to the output register a cycle later.
    assign load = verdict_vld_q && verdict_ok_q && (!out_valid_q || icmp_req_pkt_ack_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            verdict_vld_q <= 1'b0;
            verdict_ok_q  <= 1'b0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            verdict_vld_q <= (state_q == ST_CHECK);
            verdict_ok_q  <= check_ok;
            if (load) begin
                out_q       <= cap_q;
                out_valid_q <= 1'b1;
            end else if (icmp_req_pkt_ack_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Frame statistics; a check drop and a discard can finish in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            ok_cnt_q   <= ok_cnt_q + {15'd0, load};
            drop_cnt_q <= drop_cnt_q + {15'd0, verdict_vld_q && !load} + {15'd0, discard_done};
        end
    end

    assign icmp_req_pkt_o       = out_q;
    assign icmp_req_pkt_valid_o = out_valid_q;
    assign rx_ok_cnt_o          = ok_cnt_q;
    assign rx_drop_cnt_o        = drop_cnt_q;
endmodule
